ysyx_23060203_axi_rd_arb: RTL and testbench

Read-channel arbiter that shares the single memory AXI read port between the ICache refill path (IFU) and the LSU. Holds a grant from AR issue until the last R beat, so bursts never interleave. Write channels pass straight from the LSU to memory. Sits between the IFU/LSU AXI masters and the SoC/crossbar-facing AXI port.

---
 rtl/ysyx_23060203_pkg.sv | 6 +
 rtl/ysyx_23060203_axi_if.sv | 44 ++++
 rtl/ysyx_23060203_axi_rd_mux.sv | 41 ++++
 rtl/ysyx_23060203_axi_rd_arb.sv | 92 +++++++++
 tb/tb_ysyx_23060203_axi_rd_arb.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060203_pkg.sv
// ysyx_23060203_pkg: shared AXI response codes and the read-arbiter state encoding
package ysyx_23060203_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [2:0] {IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R} arb_state_t;
endpackage

// File: rtl/ysyx_23060203_axi_if.sv
// ysyx_23060203_axi_if: AXI4 bundle (AR/R/AW/W/B) with master and slave modports
//   ID_W   : transaction ID width
//   DATA_W : read/write data width (wstrb is DATA_W/8)
interface ysyx_23060203_axi_if #(
  parameter int ID_W = 4,
  parameter int DATA_W = 32
);
  logic              arvalid, arready;
  logic [31:0]       araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid, rready, rlast;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic [ID_W-1:0]   rid;
  logic              awvalid, awready;
  logic [31:0]       awaddr;
  logic [ID_W-1:0]   awid;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              wvalid, wready, wlast;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              bvalid, bready;
  logic [1:0]        bresp;
  logic [ID_W-1:0]   bid;
  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, input arready,
    input rvalid, rdata, rresp, rlast, rid, output rready,
    output awvalid, awaddr, awid, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input bvalid, bresp, bid, output bready
  );
  modport slave (
    input arvalid, araddr, arid, arlen, arsize, arburst, output arready,
    output rvalid, rdata, rresp, rlast, rid, input rready,
    input awvalid, awaddr, awid, awlen, awsize, awburst, output awready,
    input wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bresp, bid, input bready
  );
endinterface

// File: rtl/ysyx_23060203_axi_rd_mux.sv
// ysyx_23060203_axi_rd_mux: combinational AR/R steering between IFU, LSU and the shared memory port
//   grant_lsu : 1 selects the LSU, 0 the IFU
//   ar_en     : the grant currently owns the address phase
//   r_en      : the grant currently owns the data phase
//   ifu_r/lsu : upstream read requesters (slave side); mem: downstream port (read channels only)
module ysyx_23060203_axi_rd_mux #(
  parameter int ID_W = 4,
  parameter int DATA_W = 32
) (
  input logic grant_lsu,
  input logic ar_en,
  input logic r_en,
  ysyx_23060203_axi_if.slave  ifu_r,
  ysyx_23060203_axi_if.slave  lsu,
  ysyx_23060203_axi_if.master mem
);
  logic [DATA_W-1:0] rdata;
  logic [ID_W-1:0]   rid;
  assign mem.arvalid = ar_en & (grant_lsu ? lsu.arvalid : ifu_r.arvalid);
  assign mem.araddr  = grant_lsu ? lsu.araddr  : ifu_r.araddr;
  assign mem.arid    = grant_lsu ? lsu.arid    : ifu_r.arid;
  assign mem.arlen   = grant_lsu ? lsu.arlen   : ifu_r.arlen;
  assign mem.arsize  = grant_lsu ? lsu.arsize  : ifu_r.arsize;
  assign mem.arburst = grant_lsu ? lsu.arburst : ifu_r.arburst;
  assign ifu_r.arready = ar_en & ~grant_lsu & mem.arready;
  assign lsu.arready   = ar_en & grant_lsu & mem.arready;
  assign mem.rready   = r_en & (grant_lsu ? lsu.rready : ifu_r.rready);
  assign ifu_r.rvalid = r_en & ~grant_lsu & mem.rvalid;
  assign lsu.rvalid   = r_en & grant_lsu & mem.rvalid;
  // R payload fans out to both sides; only the qualified rvalid marks whose beat it is
  assign rdata = mem.rdata;
  assign rid   = mem.rid;
  assign ifu_r.rdata = rdata;
  assign lsu.rdata   = rdata;
  assign ifu_r.rid   = rid;
  assign lsu.rid     = rid;
  assign ifu_r.rresp = mem.rresp;
  assign lsu.rresp   = mem.rresp;
  assign ifu_r.rlast = mem.rlast;
  assign lsu.rlast   = mem.rlast;
endmodule

// File: rtl/ysyx_23060203_axi_rd_arb.sv
// ysyx_23060203_axi_rd_arb: shares the memory AXI read port between IFU and LSU, one whole burst per grant
//   clock     : rising-edge clock
//   reset     : asynchronous, active-low
//   ifu_r     : IFU read requester (AR/R only, write channels tied off)
//   lsu       : LSU requester; writes pass straight to mem
//   mem       : shared downstream AXI port
//   proto_err : sticky, set when R beat count and arlen disagree
module ysyx_23060203_axi_rd_arb
  import ysyx_23060203_pkg::*;
#(
  parameter int ID_W = 4,
  parameter int DATA_W = 32
) (
  input  logic clock,
  input  logic reset,
  ysyx_23060203_axi_if.slave  ifu_r,
  ysyx_23060203_axi_if.slave  lsu,
  ysyx_23060203_axi_if.master mem,
  output logic proto_err
);
  arb_state_t state, state_nxt;
  logic [7:0] len_r, beat_cnt;
  logic last_lsu, grant_lsu, ar_en, r_en, ar_hs, r_hs, pick_lsu;
  assign grant_lsu = (state == LSU_AR) | (state == LSU_R);
  assign ar_en     = (state == IFU_AR) | (state == LSU_AR);
  assign r_en      = (state == IFU_R) | (state == LSU_R);
  // mem.arvalid / mem.rready are already gated by phase inside the mux
  assign ar_hs = mem.arvalid & mem.arready;
  assign r_hs  = mem.rvalid & mem.rready;
  // on a tie the requester not served last wins; last_lsu resets to 0 so the LSU takes the first tie
  assign pick_lsu = lsu.arvalid & (~ifu_r.arvalid | ~last_lsu);
  ysyx_23060203_axi_rd_mux #(.ID_W(ID_W), .DATA_W(DATA_W)) u_mux (
    .grant_lsu(grant_lsu),
    .ar_en(ar_en),
    .r_en(r_en),
    .ifu_r(ifu_r),
    .lsu(lsu),
    .mem(mem)
  );
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:          state_nxt = pick_lsu ? LSU_AR : ifu_r.arvalid ? IFU_AR : IDLE;
      IFU_AR:        state_nxt = ar_hs ? IFU_R : IFU_AR;
      LSU_AR:        state_nxt = ar_hs ? LSU_R : LSU_AR;
      IFU_R, LSU_R:  state_nxt = (r_hs & mem.rlast) ? IDLE : state;
      default:       state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      len_r     <= '0;
      beat_cnt  <= '0;
      last_lsu  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ar_hs) begin
        len_r    <= mem.arlen;
        beat_cnt <= '0;
        last_lsu <= grant_lsu;
      end else if (r_hs) begin
        beat_cnt <= (beat_cnt == 8'hff) ? beat_cnt : beat_cnt + 8'd1;
      end
      // early rlast, or the final expected beat arriving without rlast
      if (r_hs & (mem.rlast ? (beat_cnt != len_r) : (beat_cnt == len_r)))
        proto_err <= 1'b1;
    end
  end
  assign mem.awvalid = lsu.awvalid;
  assign mem.awaddr  = lsu.awaddr;
  assign mem.awid    = lsu.awid;
  assign mem.awlen   = lsu.awlen;
  assign mem.awsize  = lsu.awsize;
  assign mem.awburst = lsu.awburst;
  assign lsu.awready = mem.awready;
  assign mem.wvalid  = lsu.wvalid;
  assign mem.wdata   = lsu.wdata;
  assign mem.wstrb   = lsu.wstrb;
  assign mem.wlast   = lsu.wlast;
  assign lsu.wready  = mem.wready;
  assign lsu.bvalid  = mem.bvalid;
  assign lsu.bresp   = mem.bresp;
  assign lsu.bid     = mem.bid;
  assign mem.bready  = lsu.bready;
  assign ifu_r.awready = 1'b0;
  assign ifu_r.wready  = 1'b0;
  assign ifu_r.bvalid  = 1'b0;
  assign ifu_r.bresp   = RESP_OKAY;
  assign ifu_r.bid     = '0;
endmodule

// File: tb/tb_ysyx_23060203_axi_rd_arb.sv
// tb_ysyx_23060203_axi_rd_arb: directed/randomized bench for the IFU/LSU read arbiter
module tb_ysyx_23060203_axi_rd_arb;
  logic clock = 1'b0;
  logic reset;
  logic proto_err;
  int pass_cnt = 0, fail_cnt = 0, total = 0;
  bit ifu_v, lsu_v, m_last, exp_err;
  int gi = 0, gl = 0;
  logic [31:0] ia, la;
  logic [7:0] il, ll;
  logic [3:0] iid, lid;
  ysyx_23060203_axi_if #(.ID_W(4), .DATA_W(32)) ifu ();
  ysyx_23060203_axi_if #(.ID_W(4), .DATA_W(32)) lsu ();
  ysyx_23060203_axi_if #(.ID_W(4), .DATA_W(32)) mem ();
  ysyx_23060203_axi_rd_arb #(.ID_W(4), .DATA_W(32)) dut (
    .clock(clock), .reset(reset), .ifu_r(ifu), .lsu(lsu), .mem(mem), .proto_err(proto_err)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic req_ifu(input logic [31:0] a, input logic [7:0] len);
    ia = a; il = len; iid = 4'($urandom);
    ifu.araddr = ia; ifu.arlen = il; ifu.arid = iid; ifu.arsize = 3'd2; ifu.arburst = 2'd1;
    ifu.arvalid = 1'b1; ifu_v = 1'b1;
  endtask
  task automatic req_lsu(input logic [31:0] a, input logic [7:0] len);
    la = a; ll = len; lid = 4'($urandom);
    lsu.araddr = la; lsu.arlen = ll; lsu.arid = lid; lsu.arsize = 3'd2; lsu.arburst = 2'd1;
    lsu.arvalid = 1'b1; lsu_v = 1'b1;
  endtask
  task automatic set_rready(input bit g, input logic v);
    if (g) lsu.rready = v; else ifu.rready = v;
  endtask
  task automatic wr_chk();
    logic [31:0] a, d;
    logic [1:0] r;
    a = $urandom; d = $urandom; r = 2'($urandom);
    lsu.awvalid = 1'b1; lsu.awaddr = a; lsu.wvalid = 1'b1; lsu.wdata = d; lsu.wstrb = 4'hf;
    mem.awready = 1'b1; mem.bvalid = 1'b1; mem.bresp = r; lsu.bready = 1'b1;
    #1;
    chk("aw_addr", mem.awaddr, a);
    chk("w_data", mem.wdata, d);
    chk("aw_ready", lsu.awready, 1);
    chk("b_resp", lsu.bresp, r);
    chk("b_ready", mem.bready, 1);
    chk("ifu_bvalid", ifu.bvalid, 0);
    lsu.awvalid = 1'b0; lsu.wvalid = 1'b0; mem.awready = 1'b0; mem.bvalid = 1'b0; lsu.bready = 1'b0;
  endtask
  // one complete read: grant predicted from the pending requests and the last winner;
  // memory returns len+1+delta beats, delta != 0 being a protocol error
  task automatic txn(input int delta, input int bp);
    bit g;
    logic [7:0] len;
    logic [31:0] d;
    logic [1:0] rs;
    int nb;
    g = lsu_v && (!ifu_v || !m_last);
    len = g ? ll : il;
    #1;
    chk("idle_ar0", mem.arvalid, 0);
    @(posedge clock); @(negedge clock);
    chk("ar_valid", mem.arvalid, 1);
    chk("ar_addr", mem.araddr, g ? la : ia);
    chk("ar_len", mem.arlen, len);
    chk("ar_id", mem.arid, g ? lid : iid);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clock);
      chk("ar_hold", mem.arvalid, 1);
    end
    mem.arready = 1'b1; #1;
    chk("ar_ready_g", g ? lsu.arready : ifu.arready, 1);
    chk("ar_ready_o", g ? ifu.arready : lsu.arready, 0);
    @(negedge clock);
    mem.arready = 1'b0;
    if (g) begin lsu.arvalid = 1'b0; lsu_v = 1'b0; gl++; end
    else begin ifu.arvalid = 1'b0; ifu_v = 1'b0; gi++; end
    m_last = g;
    nb = int'(len) + 1 + delta;
    for (int i = 0; i < nb; i++) begin
      d = $urandom; rs = 2'($urandom);
      mem.rvalid = 1'b1; mem.rdata = d; mem.rresp = rs; mem.rid = g ? lid : iid; mem.rlast = (i == nb - 1);
      set_rready(g, 1'b0);
      if (i == 1) repeat (bp) begin
        #1;
        chk("bp_rready", mem.rready, 0);
        chk("bp_rvalid", g ? lsu.rvalid : ifu.rvalid, 1);
        chk("bp_rdata", g ? lsu.rdata : ifu.rdata, d);
        @(negedge clock);
      end
      set_rready(g, 1'b1); #1;
      chk("r_valid", g ? lsu.rvalid : ifu.rvalid, 1);
      chk("r_valid_o", g ? ifu.rvalid : lsu.rvalid, 0);
      chk("r_data", g ? lsu.rdata : ifu.rdata, d);
      chk("r_resp", g ? lsu.rresp : ifu.rresp, rs);
      chk("r_ready", mem.rready, 1);
      chk("r_no_ar", mem.arvalid, 0);
      @(negedge clock);
    end
    mem.rvalid = 1'b0; mem.rlast = 1'b0;
    set_rready(g, 1'b0);
    if (delta != 0) exp_err = 1'b1;
    #1;
    chk("idle_after", mem.arvalid, 0);
    chk("proto_err", proto_err, exp_err);
  endtask
  initial begin
    int gi0, gl0;
    reset = 1'b0;
    {ifu.arvalid, ifu.araddr, ifu.arid, ifu.arlen, ifu.arsize, ifu.arburst, ifu.rready} = '0;
    {ifu.awvalid, ifu.awaddr, ifu.awid, ifu.awlen, ifu.awsize, ifu.awburst} = '0;
    {ifu.wvalid, ifu.wdata, ifu.wstrb, ifu.wlast, ifu.bready} = '0;
    {lsu.arvalid, lsu.araddr, lsu.arid, lsu.arlen, lsu.arsize, lsu.arburst, lsu.rready} = '0;
    {lsu.awvalid, lsu.awaddr, lsu.awid, lsu.awlen, lsu.awsize, lsu.awburst} = '0;
    {lsu.wvalid, lsu.wdata, lsu.wstrb, lsu.wlast, lsu.bready} = '0;
    {mem.arready, mem.rvalid, mem.rdata, mem.rresp, mem.rlast, mem.rid} = '0;
    {mem.awready, mem.wready, mem.bvalid, mem.bresp, mem.bid} = '0;
    m_last = 1'b0; exp_err = 1'b0; ifu_v = 1'b0; lsu_v = 1'b0;
    req_ifu(32'h3000_0040, 8'd1);
    req_lsu(32'h8000_0100, 8'd0);
    mem.arready = 1'b1; mem.rvalid = 1'b1; ifu.rready = 1'b1; lsu.rready = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_mem_arvalid", mem.arvalid, 0);
    chk("rst_mem_rready", mem.rready, 0);
    chk("rst_ifu_arready", ifu.arready, 0);
    chk("rst_ifu_rvalid", ifu.rvalid, 0);
    chk("rst_lsu_arready", lsu.arready, 0);
    chk("rst_lsu_rvalid", lsu.rvalid, 0);
    chk("rst_proto_err", proto_err, 0);
    mem.arready = 1'b0; mem.rvalid = 1'b0; ifu.rready = 1'b0; lsu.rready = 1'b0;
    reset = 1'b1;
    txn(0, 0);
    txn(0, 0);
    chk("tie_grants", {gi[7:0], gl[7:0]}, {8'd1, 8'd1});
    req_ifu(32'h3000_0000, 8'd3);
    txn(0, 0);
    wr_chk();
    gi0 = gi; gl0 = gl;
    for (int t = 0; t < 6; t++) begin
      if (!ifu_v) req_ifu(32'h3000_0000 | ($urandom & 32'h00ff_fffc), 8'($urandom_range(0, 3)));
      if (!lsu_v) req_lsu(32'h8000_0000 | ($urandom & 32'h00ff_fffc), 8'($urandom_range(0, 3)));
      txn(0, $urandom_range(0, 2));
    end
    ifu.arvalid = 1'b0; lsu.arvalid = 1'b0; ifu_v = 1'b0; lsu_v = 1'b0;
    chk("rr_ifu_grants", gi - gi0, 3);
    chk("rr_lsu_grants", gl - gl0, 3);
    req_lsu(32'h8000_0200, 8'd3);
    txn(0, 3);
    req_ifu(32'h3000_0080, 8'd3);
    txn(-1, 0);
    req_lsu(32'h8000_0300, 8'd1);
    txn(0, 2);
    req_ifu(32'h3000_0100, 8'd3);
    #1;
    @(posedge clock); @(negedge clock);
    mem.arready = 1'b1;
    @(negedge clock);
    mem.arready = 1'b0; ifu.arvalid = 1'b0; ifu_v = 1'b0;
    mem.rvalid = 1'b1; mem.rdata = 32'h1111_1111; ifu.rready = 1'b1;
    @(negedge clock);
    mem.rdata = 32'h2222_2222; #1;
    chk("pre_rst_rvalid", ifu.rvalid, 1);
    wr_chk();
    reset = 1'b0; #1;
    chk("arst_ifu_rvalid", ifu.rvalid, 0);
    chk("arst_mem_rready", mem.rready, 0);
    chk("arst_mem_arvalid", mem.arvalid, 0);
    chk("arst_lsu_rvalid", lsu.rvalid, 0);
    chk("arst_proto_err", proto_err, 0);
    m_last = 1'b0; exp_err = 1'b0;
    mem.rvalid = 1'b0; ifu.rready = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    req_ifu(32'h3000_0400, 8'd2);
    req_lsu(32'h8000_0400, 8'd1);
    txn(1, 0);
    txn(0, 1);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
